// File: rtl/shifter_arbiter_ctrl_pkg.sv
// Shared encodings for the shared-shifter controller.
// SHIFTER_ROTATE_EN enables the two-pass rotate state.
package shifter_arbiter_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned AMT_W  = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
`ifdef SHIFTER_ROTATE_EN
        ST_PASS2 = 2'd2,
`endif
        ST_HOLD  = 2'd3
    } state_e;

endpackage

// File: rtl/shifter_arbiter_ctrl_if.sv
// Requester and result handshake bundle; master = issuers/consumer, slave = controller.
interface shifter_arbiter_ctrl_if;
    import shifter_arbiter_ctrl_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_data;
    logic [AMT_W-1:0]  req0_amt;
    logic [1:0]        req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_data;
    logic [AMT_W-1:0]  req1_amt;
    logic [1:0]        req1_op;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_id;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_op,
        output req1_valid, req1_data, req1_amt, req1_op,
        output out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_op,
        input  req1_valid, req1_data, req1_amt, req1_op,
        input  out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_id
    );

endinterface

// File: rtl/Barrel_Shifter.sv
// 32-bit logical barrel shifter; lr_shift selects right (1) or left (0).
module Barrel_Shifter (
    input  logic [4:0]  shifamt,
    input  logic        lr_shift,
    input  logic [31:0] input_val,
    output logic [31:0] final_val
);

    assign final_val = lr_shift ? (input_val >> shifamt) : (input_val << shifamt);

endmodule

// File: rtl/shifter_arbiter_ctrl_arb.sv
// Two-way round-robin arbiter; the last-grant pointer only moves on an accepted grant.
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic accept_i,
    output logic grant0_o,
    output logic grant1_o,
    output logic grant_id_o
);

    logic last_q;
    logic last_d;

    // Contention goes to the requester that did not win last time.
    assign grant_id_o = (valid0_i && valid1_i) ? ~last_q : valid1_i;
    assign grant0_o   = valid0_i && !grant_id_o;
    assign grant1_o   = valid1_i && grant_id_o;
    assign last_d     = accept_i ? grant_id_o : last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/shifter_arbiter_ctrl.sv
// Shares one barrel shifter between two requesters; sequences shifts and rotates.
// SHIFTER_ROTATE_EN: when undefined, op[1] is ignored and every op is single-pass.
module shifter_arbiter_ctrl
    import shifter_arbiter_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    shifter_arbiter_ctrl_if.slave bus
);

    state_e            state_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] acc_q;
    logic [AMT_W-1:0]  amt_q;
    logic [1:0]        op_q;
    logic              id_q;
    logic              out_valid_q;

    logic              grant0;
    logic              grant1;
    logic              grant_id;
    logic              in_idle;
    logic              accept;
    logic [AMT_W-1:0]  sh_amt;
    logic              sh_dir;
    logic [DATA_W-1:0] sh_out;

    assign in_idle = (state_q == ST_IDLE);
    assign accept  = in_idle && (grant0 || grant1);

    rr_arbiter2 u_arb (
        .clk_i      (clock),
        .rst_ni     (resetn),
        .valid0_i   (bus.req0_valid),
        .valid1_i   (bus.req1_valid),
        .accept_i   (accept),
        .grant0_o   (grant0),
        .grant1_o   (grant1),
        .grant_id_o (grant_id)
    );

    assign bus.req0_ready = in_idle && grant0;
    assign bus.req1_ready = in_idle && grant1;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = acc_q;
    assign bus.out_id     = id_q;

    // Second rotate pass shifts the other way by (32 - amt) mod 32.
    always_comb begin
        sh_amt = amt_q;
        sh_dir = op_q[0] ? DIR_RIGHT : DIR_LEFT;
`ifdef SHIFTER_ROTATE_EN
        if (state_q == ST_PASS2) begin
            sh_amt = AMT_W'(~amt_q + 1'b1);
            sh_dir = ~sh_dir;
        end
`endif
    end

    Barrel_Shifter u_shifter (
        .shifamt   (sh_amt),
        .lr_shift  (sh_dir),
        .input_val (data_q),
        .final_val (sh_out)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            acc_q       <= '0;
            amt_q       <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= grant_id ? bus.req1_data : bus.req0_data;
                        amt_q   <= grant_id ? bus.req1_amt  : bus.req0_amt;
                        op_q    <= grant_id ? bus.req1_op   : bus.req0_op;
                        id_q    <= grant_id;
                        state_q <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    acc_q <= sh_out;
`ifdef SHIFTER_ROTATE_EN
                    if (op_q[1] && (amt_q != '0)) begin
                        state_q <= ST_PASS2;
                    end else begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
`else
                    state_q     <= ST_HOLD;
                    out_valid_q <= 1'b1;
`endif
                end
`ifdef SHIFTER_ROTATE_EN
                ST_PASS2: begin
                    acc_q       <= acc_q | sh_out;
                    state_q     <= ST_HOLD;
                    out_valid_q <= 1'b1;
                end
`endif
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_arbiter_ctrl.sv
// Directed plus random bench for shifter_arbiter_ctrl against a behavioural model.
// Honours SHIFTER_ROTATE_EN the same way as the design.
module tb_shifter_arbiter_ctrl;

    logic clock = 1'b0;
    logic resetn;
    int unsigned total = 0;
    int unsigned bad = 0;
    logic last_g = 1'b0;

    shifter_arbiter_ctrl_if bus ();

    shifter_arbiter_ctrl dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                          input logic [1:0] op);
        logic [63:0] w;
        w = {d, d};
`ifdef SHIFTER_ROTATE_EN
        if (op == 2'b10) begin
            w = w << a;
            return w[63:32];
        end
        if (op == 2'b11) begin
            w = w >> a;
            return w[31:0];
        end
`endif
        return op[0] ? (d >> a) : (d << a);
    endfunction

    task automatic run_op(input bit v0, input bit v1,
                          input logic [31:0] d0, input logic [4:0] a0, input logic [1:0] o0,
                          input logic [31:0] d1, input logic [4:0] a1, input logic [1:0] o1,
                          input int unsigned hold);
        logic g;
        logic [31:0] ed;
        int unsigned el;
        int unsigned n;
        logic [4:0] ga;
        logic [1:0] go;
        g  = (v0 && v1) ? ~last_g : v1;
        ga = g ? a1 : a0;
        go = g ? o1 : o0;
        ed = g ? model(d1, a1, o1) : model(d0, a0, o0);
`ifdef SHIFTER_ROTATE_EN
        el = (go[1] && ga != 5'd0) ? 3 : 2;
`else
        el = 2;
`endif
        bus.req0_valid = v0; bus.req0_data = d0; bus.req0_amt = a0; bus.req0_op = o0;
        bus.req1_valid = v1; bus.req1_data = d1; bus.req1_amt = a1; bus.req1_op = o1;
        bus.out_ready  = (hold == 0);
        #1;
        n = 0;
        while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
            tick();
            n++;
        end
        check("ready0", {31'd0, bus.req0_ready}, {31'd0, ~g});
        check("ready1", {31'd0, bus.req1_ready}, {31'd0, g});
        if (!(bus.req0_ready || bus.req1_ready)) return;
        last_g = g;
        tick();
        n = 1;
        while (!bus.out_valid && n < 8) begin
            tick();
            n++;
        end
        check("latency", n, el);
        check("out_data", bus.out_data, ed);
        check("out_id", {31'd0, bus.out_id}, {31'd0, g});
        for (int unsigned i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_data", bus.out_data, ed);
            check("hold_id", {31'd0, bus.out_id}, {31'd0, g});
            check("hold_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        check("xfer_done", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        logic [31:0] d;
        resetn = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_amt = '0; bus.req0_op = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_amt = '0; bus.req1_op = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_id", {31'd0, bus.out_id}, 32'd0);
        check("rst_rdy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        resetn = 1'b1;
        tick();

        run_op(1, 0, 32'h0000_0001, 5'd4, 2'b00, '0, '0, '0, 0);
        run_op(0, 1, '0, '0, '0, 32'h0000_00F1, 5'd4, 2'b11, 0);
        for (int k = 0; k < 4; k++)
            run_op(1, 1, 32'h8000_0000, 5'd31, 2'b01, 32'h8000_0000, 5'd31, 2'b01, 0);
        run_op(1, 0, 32'hDEAD_BEEF, 5'd0, 2'b10, '0, '0, '0, 0);
        run_op(0, 1, '0, '0, '0, 32'h0000_0003, 5'd31, 2'b10, 0);
        run_op(1, 1, 32'h1234_5678, 5'd0, 2'b01, 32'hCAFE_F00D, 5'd7, 2'b00, 5);

        // Reset while the first pass of a rotate is in flight.
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 32'hA5A5_0F0F; bus.req0_amt = 5'd8;
        bus.req0_op = 2'b10; bus.out_ready = 1'b1;
        #1;
        n = 0;
        while (!bus.req0_ready && n < 8) begin
            tick();
            n++;
        end
        check("rst_req_rdy", {31'd0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_data", bus.out_data, 32'd0);
        tick();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("midrst_quiet", {31'd0, bus.out_valid}, 32'd0);
        end
        last_g = 1'b0;
        run_op(1, 1, 32'h0000_0F00, 5'd4, 2'b01, 32'h0F00_0000, 5'd4, 2'b00, 0);

        for (int k = 0; k < 24; k++) begin
            bit v0;
            bit v1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            if (!v0 && !v1) v0 = 1'b1;
            d = $urandom;
            run_op(v0, v1, d, 5'($urandom), 2'($urandom), $urandom, 5'($urandom),
                   2'($urandom), $urandom_range(0, 2));
        end

        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
